// File: rtl/sha256_msg_sched_if.sv
// Block-offer and round-operand bundle between a message source, the
// SHA-256 message scheduler and the compression core.
interface sha256_msg_sched_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         load_o;
    logic         wt_valid;
    logic [31:0]  wt_o;
    logic [31:0]  kt_o;
    logic [5:0]   round_o;
    logic         done_o;

    modport master (
        output blk_valid, blk_data,
        input  blk_ready, load_o, wt_valid, wt_o, kt_o, round_o, done_o
    );

    modport slave (
        input  blk_valid, blk_data,
        output blk_ready, load_o, wt_valid, wt_o, kt_o, round_o, done_o
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: captures one 512-bit block, pulses load, then
// streams W_t/K_t for rounds 0..63 from a 16-word sliding window.
module sha256_msg_sched (
    input  logic               clk,
    input  logic               rst,
    sha256_msg_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t      state;
    logic [31:0] win [16];
    logic [5:0]  rnd;
    logic        ready_r;
    logic        load_r;
    logic        run_r;
    logic        done_r;
    logic [31:0] w_new;
    logic [31:0] w_cur;

    // Rounds 0..15 rotate the captured block through win[0]; by round 16 the
    // window holds W[t-16..t-1] and new words are derived from it.
    always_comb begin
        w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
        w_cur = (rnd[5:4] == 2'b00) ? win[0] : w_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            load_r  <= 1'b0;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            rnd     <= 6'd0;
            for (int i = 0; i < 16; i++) win[i] <= 32'd0;
        end else begin
            load_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.blk_valid) begin
                        for (int i = 0; i < 16; i++)
                            win[i] <= bus.blk_data[511 - 32*i -: 32];
                        state   <= LOAD;
                        ready_r <= 1'b0;
                        load_r  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= RUN;
                    run_r <= 1'b1;
                end
                RUN: begin
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= w_cur;
                    rnd     <= rnd + 6'd1;
                    if (rnd == 6'd63) begin
                        state   <= IDLE;
                        run_r   <= 1'b0;
                        ready_r <= 1'b1;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    run_r   <= 1'b0;
                    rnd     <= 6'd0;
                end
            endcase
        end
    end

    assign bus.blk_ready = ready_r;
    assign bus.load_o    = load_r;
    assign bus.wt_valid  = run_r;
    assign bus.done_o    = done_r;
    assign bus.wt_o      = run_r ? w_cur  : 32'd0;
    assign bus.kt_o      = run_r ? K[rnd] : 32'd0;
    assign bus.round_o   = run_r ? rnd    : 6'd0;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed and randomized checks of the SHA-256 message scheduler against
// hand-computed vectors and an array-expansion reference schedule.
module tb_sha256_msg_sched;

    localparam logic [31:0] KREF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] ref_w [64];

    sha256_msg_sched_if bif ();

    sha256_msg_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_ref(input logic [511:0] blk);
        logic [31:0] a;
        logic [31:0] b;
        for (int t = 0; t < 16; t++) ref_w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            a = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
            b = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
            ref_w[t] = a + ref_w[t-7] + b + ref_w[t-16];
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ctl"}, {bif.blk_ready, bif.load_o, bif.wt_valid, bif.done_o}, 4'b1000);
        chk({tag, "_wt"},  bif.wt_o,    32'd0);
        chk({tag, "_kt"},  bif.kt_o,    32'd0);
        chk({tag, "_rnd"}, bif.round_o, 6'd0);
    endtask

    // Called at the negedge of the accept cycle (c=0). LOAD is c=1, rounds
    // 0..63 are c=2..65, done is c=66, which is where the task returns.
    task automatic run_block(input logic [511:0] blk, input logic [511:0] nxt,
                             input bit hold, input bit directed);
        int t;
        build_ref(blk);
        bif.blk_valid = 1'b1;
        bif.blk_data  = blk;
        chk("accept_rdy", bif.blk_ready, 1'b1);
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) begin
                    bif.blk_data = nxt;
                end else begin
                    bif.blk_valid = 1'b0;
                    bif.blk_data  = {16{$urandom}};
                end
            end
            if (c == 1) begin
                chk("load_ctl", {bif.blk_ready, bif.load_o, bif.wt_valid, bif.done_o}, 4'b0100);
                chk("load_wt", bif.wt_o, 32'd0);
            end else if (c <= 65) begin
                t = c - 2;
                chk($sformatf("run_ctl_r%0d", t),
                    {bif.blk_ready, bif.load_o, bif.wt_valid, bif.done_o}, 4'b0010);
                chk($sformatf("round_r%0d", t), bif.round_o, t[5:0]);
                chk($sformatf("wt_r%0d", t), bif.wt_o, ref_w[t]);
                chk($sformatf("kt_r%0d", t), bif.kt_o, KREF[t]);
                if (t == 0) chk("w0_direct", bif.wt_o, blk[511:480]);
                if (directed) begin
                    if (t == 0)  chk("abc_wt0",  bif.wt_o, 32'h61626380);
                    if (t == 0)  chk("abc_kt0",  bif.kt_o, 32'h428a2f98);
                    if (t == 16) chk("abc_wt16", bif.wt_o, 32'h61626380);
                    if (t == 17) chk("abc_wt17", bif.wt_o, 32'h000f0000);
                    if (t == 63) chk("abc_kt63", bif.kt_o, 32'hc67178f2);
                end
            end else begin
                chk("done_ctl", {bif.blk_ready, bif.load_o, bif.wt_valid, bif.done_o}, 4'b1001);
                chk("done_wt", bif.wt_o, 32'd0);
            end
        end
    endtask

    task automatic reset_mid(input logic [511:0] blk);
        bif.blk_valid = 1'b1;
        bif.blk_data  = blk;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            bif.blk_valid = 1'b0;
        end
        chk("mid_round30", bif.round_o, 6'd30);
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_rel");
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        logic [511:0] rblk;

        rst           = 1'b1;
        bif.blk_valid = 1'b0;
        bif.blk_data  = '0;
        abc = {32'h61626380, 448'h0, 32'h00000018};

        repeat (2) @(negedge clk);
        check_idle("reset");
        bif.blk_valid = 1'b1;
        bif.blk_data  = abc;
        @(negedge clk);
        check_idle("reset_valid_ignored");
        bif.blk_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        run_block(abc, '0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            blk_a[511 - 32*i -: 32] = $urandom;
            blk_b[511 - 32*i -: 32] = $urandom;
        end
        run_block(blk_a, blk_b, 1'b1, 1'b0);
        run_block(blk_b, '0, 1'b0, 1'b0);

        reset_mid(abc);
        run_block(abc, '0, 1'b0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            if (n % 250 == 7) begin
                rblk = '1;
            end else begin
                for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
                if (n % 50 == 3) rblk[255:0] = '1;
            end
            run_block(rblk, '0, 1'b0, 1'b0);
        end

        @(negedge clk);
        check_idle("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
